pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the five-stage MIPS core: sequences the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Collects stall requests from ID (load-use), EX (multi-cycle operation) and MEM (memory wait) and drives one per-stage stall vector.
- Turns a redirect/exception request into a one-cycle pipeline flush with a registered target PC.
- Keeps stall and flush performance counters.
- Sits beside the top-level pipeline; its outputs fan out to `pc_reg` and every pipeline register.

## Interface
- TIMEOUT_CYCLES, 1024, consecutive stalled cycles before `timeout_o` sets (only with STALL_TIMEOUT_EN)
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- stallreq_id  in  1  ID requests stall (load-use hazard)
- stallreq_ex  in  1  EX requests stall (multi-cycle op busy)
- stallreq_mem  in  1  MEM requests stall (data bus wait)
- flush_req  in  1  redirect/exception; flush all stages
- flush_pc_i  in  32  PC to fetch after flush
- stall_o  out  6  hold per stage: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB
- flush_o  out  1  clear all pipeline registers, load `new_pc_o` into PC
- new_pc_o  out  32  registered flush target
- stall_cycles_o  out  32  total stalled cycles, wraps
- flush_count_o  out  16  total flushes, wraps
- timeout_o  out  1  sticky stall-timeout flag

## Operation
- Stall vector is combinational from the requests; the highest requesting stage wins:
  - `stallreq_mem` -> 6'b011111
  - else `stallreq_ex` -> 6'b001111
  - else `stallreq_id` -> 6'b000111
  - else 6'b000000
- A stage holds while its bit is 1.
- Where bit k=1 and bit k+1=0, the stage k+1 register loads a bubble (NOP, wreg=0).
- WB bit [5] is always 0.
- Flush beats stall: `stall_o` = 0 whenever `flush_req`=1 or state=FLUSH.
- FSM states:
  - RUN: no stall, no flush.
  - STALL: a stall is in force this cycle.
  - FLUSH: `flush_o`=1.
- Transitions, evaluated each clk:
  - `flush_req` -> FLUSH, from any state.
  - else any stallreq -> STALL.
  - else -> RUN.
- On accepting `flush_req`: capture `new_pc_o` <= `flush_pc_i`; `flush_count_o` += 1.
- `flush_req` held high in FLUSH: stay in FLUSH, recapture the PC, count again (one count per cycle asserted).
- `stall_cycles_o` += 1 for every cycle in which `stall_o` != 0.
- Consecutive-stall counter `run_cnt` (11 bits for the default):
  - Increments on each cycle with `stall_o` != 0.
  - Clears on any cycle with `stall_o` = 0.
  - Saturates at TIMEOUT_CYCLES.
- Counters wrap modulo 2^width; no saturation.

## Timing
- `stall_o`: zero latency, same cycle as the request. Pipeline registers sample it on the next clk.
- `flush_o` and `new_pc_o`: one-cycle latency. `flush_req` high at edge N gives `flush_o`=1 during cycle N+1, for exactly one cycle per accepted request.
- Stall requests arriving in the same cycle as `flush_req`, or during FLUSH, are masked and not counted.
- Reset values: state=RUN, `stall_o`=0, `flush_o`=0, `new_pc_o`=0, `stall_cycles_o`=0, `flush_count_o`=0, `run_cnt`=0, `timeout_o`=0.
- `rst` mid-stall or mid-flush: everything returns to reset values at the next edge. The pending flush is dropped.
- Requests withdrawn the same cycle they drop: `stall_o` drops the same cycle. The FSM reaches RUN at the next edge.

## Configuration
- STALL_TIMEOUT_EN defined:
  - `timeout_o` sets on the edge where `run_cnt` reaches TIMEOUT_CYCLES while `stall_o` != 0.
  - It stays 1 until `rst`.
  - The stall behaviour is unchanged.
- STALL_TIMEOUT_EN undefined: `run_cnt` logic is absent and `timeout_o` is tied to 0.

## Structure
- Stall-vector encodings, FSM state codes, stage bit indices and the NOP/bubble constants go in the shared defines file next to `RegBus`/`InstAddrBus`.
- Sub-module `stall_timer` holds `run_cnt` and `timeout_o`. It is instantiated only under STALL_TIMEOUT_EN.

## Test plan
- Reset, then idle 5 cycles -> all outputs 0, state RUN.
- `stallreq_ex`=1 for 3 cycles -> `stall_o`=6'b001111 in the same cycles, `stall_cycles_o`=3, then 0 the cycle after release.
- `stallreq_id`=1 and `stallreq_mem`=1 together -> `stall_o`=6'b011111; drop mem only -> 6'b000111.
- `stallreq_ex`=1 and `flush_req`=1 with `flush_pc_i`=32'h0000_0040 in one cycle -> `stall_o`=0 that cycle; next cycle `flush_o`=1, `new_pc_o`=32'h40, `flush_count_o`=1; no stall counted.
- `flush_req` held 2 cycles, pc 32'h100 then 32'h200 -> `flush_o` high 2 cycles, `new_pc_o` 32'h100 then 32'h200, `flush_count_o`=2.
- STALL_TIMEOUT_EN, TIMEOUT_CYCLES=8: `stallreq_mem` held 8 cycles -> `timeout_o` rises after the 8th stalled edge and stays 1 after release; 7-cycle stall, 1 idle, 7-cycle stall -> `timeout_o` stays 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: bus widths, stall encodings, stage indices,
// bubble constants and the control FSM state codes.
package pipe_ctrl_pkg;

    localparam int unsigned REG_BUS_W     = 32;
    localparam int unsigned INST_ADDR_W   = 32;
    localparam int unsigned STALL_W       = 6;
    localparam int unsigned FLUSH_CNT_W   = 16;

    typedef logic [REG_BUS_W-1:0]   reg_bus_t;
    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [STALL_W-1:0]     stall_vec_t;

    localparam int unsigned STG_PC  = 0;
    localparam int unsigned STG_IF  = 1;
    localparam int unsigned STG_ID  = 2;
    localparam int unsigned STG_EX  = 3;
    localparam int unsigned STG_MEM = 4;
    localparam int unsigned STG_WB  = 5;

    localparam stall_vec_t STALL_NONE = 6'b000000;
    localparam stall_vec_t STALL_ID   = 6'b000111;
    localparam stall_vec_t STALL_EX   = 6'b001111;
    localparam stall_vec_t STALL_MEM  = 6'b011111;

    // Bubble loaded into the register just below the lowest held stage.
    localparam reg_bus_t NOP_INST     = 32'h0000_0000;
    localparam logic     NOP_WREG     = 1'b0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } pipe_state_e;

    function automatic stall_vec_t encode_stall(input logic req_id,
                                                input logic req_ex,
                                                input logic req_mem);
        if (req_mem)     return STALL_MEM;
        else if (req_ex) return STALL_EX;
        else if (req_id) return STALL_ID;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_timer.sv
// Consecutive-stall timer: counts back-to-back stalled cycles and raises a sticky
// timeout once the run length reaches TIMEOUT_CYCLES. Used only with STALL_TIMEOUT_EN.
module pipe_ctrl_stall_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_active,
    output logic timeout_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        run_cnt_d = run_cnt_q;
        timeout_d = timeout_q;
        if (!stall_active) begin
            run_cnt_d = '0;
        end else if (run_cnt_q != CNT_MAX) begin
            run_cnt_d = run_cnt_q + 1'b1;
        end
        if (stall_active && (run_cnt_d == CNT_MAX)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: per-stage stall vector, one-cycle flush with registered target
// PC, and stall/flush counters. Optional stall timeout enabled by STALL_TIMEOUT_EN.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_RUN   | no stall, no flush in force
// ST_STALL | a stall request was seen on the last edge
// ST_FLUSH | flush_o=1 this cycle, new_pc_o holds the target
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallreq_id,
    input  logic                   stallreq_ex,
    input  logic                   stallreq_mem,
    input  logic                   flush_req,
    input  logic [INST_ADDR_W-1:0] flush_pc_i,
    output logic [STALL_W-1:0]     stall_o,
    output logic                   flush_o,
    output logic [INST_ADDR_W-1:0] new_pc_o,
    output logic [REG_BUS_W-1:0]   stall_cycles_o,
    output logic [FLUSH_CNT_W-1:0] flush_count_o,
    output logic                   timeout_o
);

    if (TIMEOUT_CYCLES < 2) begin : g_cfg_check
        $error("pipe_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    pipe_state_e            state_q, state_d;
    inst_addr_t             new_pc_q, new_pc_d;
    reg_bus_t               stall_cycles_q, stall_cycles_d;
    logic [FLUSH_CNT_W-1:0] flush_count_q, flush_count_d;
    stall_vec_t             stall_vec;
    logic                   stall_active;
    logic                   any_req;

    assign any_req = stallreq_id | stallreq_ex | stallreq_mem;

    // Flush beats stall: a request alongside or during a flush is masked and not counted.
    always_comb begin
        stall_vec = encode_stall(stallreq_id, stallreq_ex, stallreq_mem);
        if (flush_req || (state_q == ST_FLUSH)) begin
            stall_vec = STALL_NONE;
        end
        stall_vec[STG_WB] = 1'b0;
    end

    assign stall_active = (stall_vec != STALL_NONE);

    always_comb begin
        state_d        = ST_RUN;
        new_pc_d       = new_pc_q;
        flush_count_d  = flush_count_q;
        stall_cycles_d = stall_cycles_q;
        if (flush_req) begin
            state_d       = ST_FLUSH;
            new_pc_d      = flush_pc_i;
            flush_count_d = flush_count_q + 1'b1;
        end else if (any_req) begin
            state_d = ST_STALL;
        end
        if (stall_active) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            new_pc_q       <= '0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            new_pc_q       <= new_pc_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_o        = stall_vec;
    assign flush_o        = (state_q == ST_FLUSH);
    assign new_pc_o       = new_pc_q;
    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;

`ifdef STALL_TIMEOUT_EN
    pipe_ctrl_stall_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clk          (clk),
        .rst          (rst),
        .stall_active (stall_active),
        .timeout_o    (timeout_o)
    );
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl; the timeout section is exercised when STALL_TIMEOUT_EN is defined.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, stallreq_mem;
    logic        flush_req;
    logic [31:0] flush_pc_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [31:0] stall_cycles_o;
    logic [15:0] flush_count_o;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_id    (stallreq_id),
        .stallreq_ex    (stallreq_ex),
        .stallreq_mem   (stallreq_mem),
        .flush_req      (flush_req),
        .flush_pc_i     (flush_pc_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .new_pc_o       (new_pc_o),
        .stall_cycles_o (stall_cycles_o),
        .flush_count_o  (flush_count_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one edge; inputs are then changed and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        flush_req = 0; flush_pc_i = '0;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("idle_stall",   {26'd0, stall_o}, 32'h0);
        check("idle_flush",   {31'd0, flush_o}, 32'h0);
        check("idle_newpc",   new_pc_o, 32'h0);
        check("idle_scnt",    stall_cycles_o, 32'h0);
        check("idle_fcnt",    {16'd0, flush_count_o}, 32'h0);
        check("idle_timeout", {31'd0, timeout_o}, 32'h0);

        // EX stall for 3 cycles
        stallreq_ex = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("ex_stall_vec", {26'd0, stall_o}, 32'h0000_000f);
            step();
        end
        stallreq_ex = 0;
        settle();
        check("ex_release_vec", {26'd0, stall_o}, 32'h0);
        check("ex_scnt", stall_cycles_o, 32'd3);
        step();
        check("ex_scnt_hold", stall_cycles_o, 32'd3);

        // MEM beats ID, then ID alone
        stallreq_id = 1; stallreq_mem = 1;
        settle();
        check("mem_id_vec", {26'd0, stall_o}, 32'h0000_001f);
        step();
        stallreq_mem = 0;
        settle();
        check("id_vec", {26'd0, stall_o}, 32'h0000_0007);
        step();
        stallreq_id = 0;
        settle();
        check("prio_scnt", stall_cycles_o, 32'd5);

        // Flush and EX stall together: flush wins, stall not counted
        stallreq_ex = 1; flush_req = 1; flush_pc_i = 32'h0000_0040;
        settle();
        check("flush_mask_vec", {26'd0, stall_o}, 32'h0);
        step();
        stallreq_ex = 0; flush_req = 0;
        check("flush1_o",     {31'd0, flush_o}, 32'h1);
        check("flush1_newpc", new_pc_o, 32'h40);
        check("flush1_fcnt",  {16'd0, flush_count_o}, 32'd1);
        check("flush1_scnt",  stall_cycles_o, 32'd5);
        step();
        check("flush1_done", {31'd0, flush_o}, 32'h0);

        // Flush held two cycles
        flush_req = 1; flush_pc_i = 32'h100;
        step();
        flush_pc_i = 32'h200;
        check("hold_a_o",     {31'd0, flush_o}, 32'h1);
        check("hold_a_newpc", new_pc_o, 32'h100);
        check("hold_a_fcnt",  {16'd0, flush_count_o}, 32'd2);
        step();
        flush_req = 0;
        check("hold_b_o",     {31'd0, flush_o}, 32'h1);
        check("hold_b_newpc", new_pc_o, 32'h200);
        check("hold_b_fcnt",  {16'd0, flush_count_o}, 32'd3);
        step();
        check("hold_done", {31'd0, flush_o}, 32'h0);

        // Stall request arriving during FLUSH is masked
        flush_req = 1; flush_pc_i = 32'h80;
        step();
        flush_req = 0; stallreq_ex = 1;
        settle();
        check("inflush_vec", {26'd0, stall_o}, 32'h0);
        step();
        check("inflush_scnt", stall_cycles_o, 32'd5);
        check("postflush_vec", {26'd0, stall_o}, 32'h0000_000f);
        step();
        stallreq_ex = 0;
        check("postflush_scnt", stall_cycles_o, 32'd6);

        // Reset mid-flush drops the pending flush
        flush_req = 1; flush_pc_i = 32'h300;
        step();
        check("pre_rst_fcnt", {16'd0, flush_count_o}, 32'd5);
        rst = 1;
        step();
        rst = 0; flush_req = 0;
        check("rst_flush", {31'd0, flush_o}, 32'h0);
        check("rst_newpc", new_pc_o, 32'h0);
        check("rst_fcnt",  {16'd0, flush_count_o}, 32'h0);
        check("rst_scnt",  stall_cycles_o, 32'h0);

`ifdef STALL_TIMEOUT_EN
        stallreq_mem = 1;
        for (int i = 0; i < 7; i++) begin
            step();
            check("to_pre", {31'd0, timeout_o}, 32'h0);
        end
        step();
        stallreq_mem = 0;
        check("to_set", {31'd0, timeout_o}, 32'h1);
        step();
        check("to_sticky", {31'd0, timeout_o}, 32'h1);
        rst = 1; step(); rst = 0;
        check("to_rst", {31'd0, timeout_o}, 32'h0);
        for (int r = 0; r < 2; r++) begin
            stallreq_mem = 1;
            for (int i = 0; i < 7; i++) step();
            stallreq_mem = 0;
            step();
            check("to_gap", {31'd0, timeout_o}, 32'h0);
        end
        check("to_gap_scnt", stall_cycles_o, 32'd14);
`else
        stallreq_mem = 1;
        for (int i = 0; i < 12; i++) step();
        stallreq_mem = 0;
        check("to_off", {31'd0, timeout_o}, 32'h0);
        check("to_off_scnt", stall_cycles_o, 32'd12);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
